// File: rtl/bram_bist_ctrl_if.sv
// Pin bundle between the BIST controller and one write/read port pair of a BRAM.
// Contract: WEN/WR_ADDR/WDATA and REN/RD_ADDR are registered by the master; RDATA is valid one cycle after REN.
interface bram_bist_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
);
  logic                  WEN;
  logic [ADDR_WIDTH-1:0] WR_ADDR;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  REN;
  logic [ADDR_WIDTH-1:0] RD_ADDR;
  logic [DATA_WIDTH-1:0] RDATA;

  modport master (output WEN, WR_ADDR, WDATA, REN, RD_ADDR, input RDATA);
  modport slave  (input WEN, WR_ADDR, WDATA, REN, RD_ADDR, output RDATA);
endinterface

// File: rtl/bram_bist_ctrl.sv
// BRAM self-test: writes a deterministic pattern over an address window, reads it back and
// compares every word, reporting pass/fail, a saturating error count and the first failing address.
module bram_bist_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 18,
    parameter int BASE_ADDR  = 0,
    parameter int COUNT      = 512,
    parameter int PAT_OFFSET = 0
) (
    input  logic                  clk,
    input  logic                  RESET_ni,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [2:0]            dbg_state,
    bram_bist_ctrl_if.master      ram
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   LAST_IDX = (ADDR_WIDTH+1)'(COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam bit                    EMPTY    = (COUNT == 0);

    state_t                state, state_n;
    logic [ADDR_WIDTH:0]   idx;
    logic [ADDR_WIDTH-1:0] addr, cur_addr;
    logic                  phase_start, last, accept;
    logic [DATA_WIDTH-1:0] exp_data, chk_data;
    logic [ADDR_WIDTH-1:0] exp_addr, chk_addr;
    logic                  chk_valid, mismatch;
    logic [15:0]           err_cnt_n;

    // 32-bit pattern, zero-extended when the RAM is wider than 32 bits
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] v;
        logic [63:0] w;
        v = 32'(a) + 32'(PAT_OFFSET);
        w = {32'd0, v | (v << 20) | 32'h0005_5000};
        return w[DATA_WIDTH-1:0];
    endfunction

    assign accept    = start && (state == S_IDLE || state == S_DONE);
    assign last      = (idx == LAST_IDX);
    assign mismatch  = chk_valid && (ram.RDATA !== chk_data);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge RESET_ni) begin
        if (!RESET_ni) state <= S_IDLE;
        else           state <= state_n;
    end

    always_comb begin
        state_n     = state;
        phase_start = 1'b0;
        cur_addr    = addr + 1'b1;
        err_cnt_n   = err_cnt;
        case (state)
            S_IDLE, S_DONE: if (start) state_n = EMPTY ? S_DONE : S_WRITE;
            S_WRITE:        if (last) state_n = S_READ;
            S_READ:         if (last) state_n = S_DRAIN;
            S_DRAIN:        state_n = S_DONE;
            default:        state_n = S_IDLE;
        endcase
        // Entering WRITE or READ restarts the walk at the window base
        if (state_n != state) begin
            phase_start = 1'b1;
            cur_addr    = BASE;
        end
        if (mismatch && err_cnt != 16'hFFFF) err_cnt_n = err_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge RESET_ni) begin
        if (!RESET_ni) begin
            idx            <= '0;
            addr           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            ram.WEN        <= 1'b0;
            ram.WR_ADDR    <= '0;
            ram.WDATA      <= '0;
            ram.REN        <= 1'b0;
            ram.RD_ADDR    <= '0;
            exp_data       <= '0;
            exp_addr       <= '0;
            chk_valid      <= 1'b0;
            chk_data       <= '0;
            chk_addr       <= '0;
        end else begin
            ram.WEN   <= (state_n == S_WRITE);
            ram.REN   <= (state_n == S_READ);
            busy      <= (state_n == S_WRITE) || (state_n == S_READ) || (state_n == S_DRAIN);
            chk_valid <= ram.REN;
            chk_data  <= exp_data;
            chk_addr  <= exp_addr;

            if (state_n == S_WRITE || state_n == S_READ) begin
                addr <= cur_addr;
                idx  <= phase_start ? '0 : idx + 1'b1;
            end
            if (state_n == S_WRITE) begin
                ram.WR_ADDR <= cur_addr;
                ram.WDATA   <= pattern(cur_addr);
            end
            if (state_n == S_READ) begin
                ram.RD_ADDR <= cur_addr;
                exp_data    <= pattern(cur_addr);
                exp_addr    <= cur_addr;
            end

            if (accept) begin
                err_cnt        <= '0;
                first_err_addr <= '0;
                pass           <= EMPTY;
                done           <= EMPTY;
            end else begin
                err_cnt <= err_cnt_n;
                if (mismatch && err_cnt == 16'd0) first_err_addr <= chk_addr;
                // The last read word is compared during DRAIN, so the verdict uses the updated count
                if (state == S_DRAIN) begin
                    done <= 1'b1;
                    pass <= (err_cnt_n == 16'd0);
                end
            end
        end
    end

endmodule
